// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file operation sequencer: instruction classes,
// branch conditions, FSM states and the decoded control vector.
package rf_seq_pkg;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [3:0] {
    ALU    = 4'd0,
    ALUI   = 4'd1,
    SUB    = 4'd2,
    LUI    = 4'd3,
    AUIPC  = 4'd4,
    JAL    = 4'd5,
    LOAD   = 4'd6,
    STORE  = 4'd7,
    BRANCH = 4'd8
  } op_class_e;

  typedef enum logic [1:0] {
    LT  = 2'd0,
    GE  = 2'd1,
    LTU = 2'd2,
    GEU = 2'd3
  } br_cond_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    BR_CHK  = 3'd2,
    MEM_REQ = 3'd3,
    MEM_WB  = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic write_en;
    logic op_enable;
    logic data2bus_en;
    logic exp_go_up;
    logic exp_go_dn;
    logic buffer_read;
    logic buffer_write;
    logic buffer_go_up;
    logic inv_en;
    logic imm_en;
    logic imm_up_en;
    logic dataFM_en;
    logic pc_plus_en;
    logic pc_imm_en;
    logic carry_in;
    logic mem_req;
    logic mem_we;
    logic done;
    logic in_ready;
  } ctrl_t;

endpackage

// File: rtl/rf_seq_strobe_dec.sv
// Moore decode of (state, latched instruction class) into every register-file
// strobe and handshake output of the sequencer. Purely combinational.
module rf_seq_strobe_dec
  import rf_seq_pkg::*;
(
  input  state_e      state,
  input  logic [3:0]  op_class,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      IDLE: ctrl.in_ready = 1'b1;
      EXEC: begin
        case (op_class)
          ALU, ALUI, SUB: begin
            ctrl.op_enable   = 1'b1;
            ctrl.data2bus_en = 1'b1;
            ctrl.write_en    = 1'b1;
            ctrl.imm_en      = (op_class == ALUI);
            ctrl.inv_en      = (op_class == SUB);
            ctrl.carry_in    = (op_class == SUB);
          end
          LUI: begin
            ctrl.imm_up_en = 1'b1;
            ctrl.write_en  = 1'b1;
          end
          AUIPC: begin
            ctrl.pc_imm_en = 1'b1;
            ctrl.write_en  = 1'b1;
          end
          JAL: begin
            ctrl.pc_plus_en = 1'b1;
            ctrl.write_en   = 1'b1;
          end
          LOAD, STORE: begin
            ctrl.op_enable   = 1'b1;
            ctrl.exp_go_up   = 1'b1;
            ctrl.imm_en      = 1'b1;
            ctrl.data2bus_en = (op_class == STORE);
          end
          // rs1 + ~rs2 + 1 lands in the buffer row for the flag check
          BRANCH: begin
            ctrl.op_enable    = 1'b1;
            ctrl.data2bus_en  = 1'b1;
            ctrl.inv_en       = 1'b1;
            ctrl.carry_in     = 1'b1;
            ctrl.exp_go_dn    = 1'b1;
            ctrl.buffer_write = 1'b1;
          end
          default: ;
        endcase
      end
      MEM_REQ: begin
        ctrl.op_enable = 1'b1;
        ctrl.exp_go_up = 1'b1;
        ctrl.imm_en    = 1'b1;
        ctrl.mem_req   = 1'b1;
        ctrl.mem_we    = (op_class == STORE);
      end
      MEM_WB: begin
        ctrl.dataFM_en = 1'b1;
        ctrl.write_en  = 1'b1;
      end
      DONE: ctrl.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Multi-cycle control sequencer for the in-memory-compute register file.
// Define RF_SEQ_TIMEOUT_EN to bound the memory wait by TIMEOUT_CYCLES and pulse err.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op_class,
  input  logic [1:0] br_cond,
  input  logic [3:0] fa_op,
  input  logic [4:0] rd_index,
  input  logic [4:0] rs1_index,
  input  logic [4:0] rs2_index,
  output logic [4:0] rf_rd_index,
  output logic [4:0] rf_rs1_index,
  output logic [4:0] rf_rs2_index,
  output logic [3:0] rf_op_fa,
  output logic       write_en,
  output logic       op_enable,
  output logic       data2bus_en,
  output logic       exp_go_up,
  output logic       exp_go_dn,
  output logic       buffer_read,
  output logic       buffer_write,
  output logic       buffer_go_up,
  output logic       inv_en,
  output logic       imm_en,
  output logic       imm_up_en,
  output logic       dataFM_en,
  output logic       pc_plus_en,
  output logic       pc_imm_en,
  output logic       carry_in,
  input  logic       buffer_msb,
  input  logic       buffer_carry_out,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ack,
  output logic       done,
  output logic       branch_taken,
  output logic       err
);

  state_e      state_reg, state_next;
  logic [3:0]  cls_reg;
  logic [1:0]  cond_reg;
  logic [3:0]  fa_reg;
  logic [4:0]  rd_reg, rs1_reg, rs2_reg;
  logic        taken_reg, taken_next;
  logic        handshake;
  logic        timeout_hit;
  ctrl_t       ctrl;

  assign handshake = in_valid && (state_reg == IDLE);

`ifdef RF_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;
  logic        err_reg;

  // Counter sits at zero outside MEM_REQ, so it is already clear on entry
  assign timeout_hit = (state_reg == MEM_REQ) && !mem_ack &&
                       (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == MEM_REQ) ? wait_cnt_reg + 16'd1 : '0;
      err_reg      <= timeout_hit;
    end
  end

  assign err = err_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    taken_next = taken_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = EXEC;
          taken_next = 1'b0;
        end
      end
      EXEC: begin
        case (cls_reg)
          LOAD, STORE: state_next = MEM_REQ;
          BRANCH:      state_next = BR_CHK;
          default:     state_next = DONE;
        endcase
      end
      BR_CHK: begin
        state_next = DONE;
        case (cond_reg)
          LT:      taken_next = buffer_msb;
          GE:      taken_next = !buffer_msb;
          LTU:     taken_next = !buffer_carry_out;
          default: taken_next = buffer_carry_out;
        endcase
      end
      MEM_REQ: begin
        if (mem_ack) begin
          state_next = (cls_reg == STORE) ? DONE : MEM_WB;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      MEM_WB:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      taken_reg <= 1'b0;
      cls_reg   <= '0;
      cond_reg  <= '0;
      fa_reg    <= '0;
      rd_reg    <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
    end else begin
      state_reg <= state_next;
      taken_reg <= taken_next;
      if (handshake) begin
        cls_reg  <= op_class;
        cond_reg <= br_cond;
        fa_reg   <= fa_op;
        rd_reg   <= rd_index;
        rs1_reg  <= rs1_index;
        rs2_reg  <= rs2_index;
      end
    end
  end

  rf_seq_strobe_dec u_dec (
    .state    (state_reg),
    .op_class (cls_reg),
    .ctrl     (ctrl)
  );

  assign in_ready     = ctrl.in_ready;
  assign write_en     = ctrl.write_en;
  assign op_enable    = ctrl.op_enable;
  assign data2bus_en  = ctrl.data2bus_en;
  assign exp_go_up    = ctrl.exp_go_up;
  assign exp_go_dn    = ctrl.exp_go_dn;
  assign buffer_read  = ctrl.buffer_read;
  assign buffer_write = ctrl.buffer_write;
  assign buffer_go_up = ctrl.buffer_go_up;
  assign inv_en       = ctrl.inv_en;
  assign imm_en       = ctrl.imm_en;
  assign imm_up_en    = ctrl.imm_up_en;
  assign dataFM_en    = ctrl.dataFM_en;
  assign pc_plus_en   = ctrl.pc_plus_en;
  assign pc_imm_en    = ctrl.pc_imm_en;
  assign carry_in     = ctrl.carry_in;
  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign done         = ctrl.done;
  assign branch_taken = ctrl.done & taken_reg;

  assign rf_op_fa     = fa_reg;
  assign rf_rd_index  = rd_reg;
  assign rf_rs1_index = rs1_reg;
  assign rf_rs2_index = rs2_reg;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomized self-checking bench for rf_op_sequencer: each instruction is expanded
// into its expected cycle-by-cycle outputs from the class rules and compared.
module tb_rf_op_sequencer;
  import rf_seq_pkg::*;

  localparam int TO = 4;

  // strobe vector bit weights
  localparam logic [14:0] WE  = 15'h4000, OPE = 15'h2000, D2B = 15'h1000, EGU = 15'h0800;
  localparam logic [14:0] EGD = 15'h0400, BW  = 15'h0100, INV = 15'h0040, IMM = 15'h0020;
  localparam logic [14:0] IMU = 15'h0010, DFM = 15'h0008, PCP = 15'h0004, PCI = 15'h0002;
  localparam logic [14:0] CIN = 15'h0001;
  // control vector bit weights
  localparam logic [5:0] C_RDY = 6'h20, C_MREQ = 6'h10, C_MWE = 6'h08;
  localparam logic [5:0] C_DONE = 6'h04, C_BT = 6'h02, C_ERR = 6'h01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] op_class = '0;
  logic [1:0] br_cond = '0;
  logic [3:0] fa_op = '0;
  logic [4:0] rd_index = '0, rs1_index = '0, rs2_index = '0;
  logic [4:0] rf_rd_index, rf_rs1_index, rf_rs2_index;
  logic [3:0] rf_op_fa;
  logic write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn, buffer_read, buffer_write;
  logic buffer_go_up, inv_en, imm_en, imm_up_en, dataFM_en, pc_plus_en, pc_imm_en, carry_in;
  logic buffer_msb = 1'b0, buffer_carry_out = 1'b0;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic done, branch_taken, err;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  rf_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .br_cond(br_cond), .fa_op(fa_op),
    .rd_index(rd_index), .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rf_rd_index(rf_rd_index), .rf_rs1_index(rf_rs1_index), .rf_rs2_index(rf_rs2_index),
    .rf_op_fa(rf_op_fa), .write_en(write_en), .op_enable(op_enable),
    .data2bus_en(data2bus_en), .exp_go_up(exp_go_up), .exp_go_dn(exp_go_dn),
    .buffer_read(buffer_read), .buffer_write(buffer_write), .buffer_go_up(buffer_go_up),
    .inv_en(inv_en), .imm_en(imm_en), .imm_up_en(imm_up_en), .dataFM_en(dataFM_en),
    .pc_plus_en(pc_plus_en), .pc_imm_en(pc_imm_en), .carry_in(carry_in),
    .buffer_msb(buffer_msb), .buffer_carry_out(buffer_carry_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .done(done), .branch_taken(branch_taken), .err(err)
  );

  always #5 clk = ~clk;

  wire [14:0] strb = {write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn, buffer_read,
                      buffer_write, buffer_go_up, inv_en, imm_en, imm_up_en, dataFM_en,
                      pc_plus_en, pc_imm_en, carry_in};
  wire [5:0]  ctl  = {in_ready, mem_req, mem_we, done, branch_taken, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle, 1 time unit after the clock edge.
  task automatic run_instr(input logic [3:0] cls, input logic [1:0] cond, input logic [3:0] fa,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int n_ack, input bit msb, input bit cout, input bit hold);
    logic [14:0] es[$];
    logic [5:0]  ec[$];
    logic [14:0] exec_s;
    bit taken;
    bit timed_out;
    int mreq_len;
    taken = 1'b0;
    timed_out = 1'b0;
    mreq_len = n_ack;
    case (cls)
      ALU:     exec_s = OPE | D2B | WE;
      ALUI:    exec_s = OPE | D2B | WE | IMM;
      SUB:     exec_s = OPE | D2B | WE | INV | CIN;
      LUI:     exec_s = IMU | WE;
      AUIPC:   exec_s = PCI | WE;
      JAL:     exec_s = PCP | WE;
      LOAD:    exec_s = OPE | EGU | IMM;
      STORE:   exec_s = OPE | EGU | IMM | D2B;
      BRANCH:  exec_s = OPE | D2B | INV | CIN | EGD | BW;
      default: exec_s = '0;
    endcase
    es.push_back(exec_s);
    ec.push_back(6'h0);
    if (cls == LOAD || cls == STORE) begin
`ifdef RF_SEQ_TIMEOUT_EN
      if (n_ack > TO) begin
        mreq_len = TO;
        timed_out = 1'b1;
      end
`endif
      for (int i = 0; i < mreq_len; i++) begin
        es.push_back(OPE | EGU | IMM);
        ec.push_back(C_MREQ | ((cls == STORE) ? C_MWE : 6'h0));
      end
      if (!timed_out && cls == LOAD) begin
        es.push_back(DFM | WE);
        ec.push_back(6'h0);
      end
    end else if (cls == BRANCH) begin
      es.push_back(15'h0);
      ec.push_back(6'h0);
      case (cond)
        LT:      taken = msb;
        GE:      taken = !msb;
        LTU:     taken = !cout;
        default: taken = cout;
      endcase
    end
    if (!timed_out) begin
      es.push_back(15'h0);
      ec.push_back(C_DONE | (taken ? C_BT : 6'h0));
    end

    chk("idle_ctl", ctl, C_RDY | (exp_err ? C_ERR : 6'h0));
    chk("idle_strb", strb, 15'h0);
    exp_err = 1'b0;
    in_valid = 1'b1;
    op_class = cls; br_cond = cond; fa_op = fa;
    rd_index = rd; rs1_index = rs1; rs2_index = rs2;
    mem_ack = 1'($urandom_range(0, 1));
    buffer_msb = 1'($urandom_range(0, 1));
    buffer_carry_out = 1'($urandom_range(0, 1));
    tick();
    for (int k = 0; k < es.size(); k++) begin
      in_valid = hold;
      op_class = 4'($urandom); br_cond = 2'($urandom); fa_op = 4'($urandom);
      rd_index = 5'($urandom); rs1_index = 5'($urandom); rs2_index = 5'($urandom);
      buffer_msb       = (cls == BRANCH && k == 1) ? msb  : 1'($urandom_range(0, 1));
      buffer_carry_out = (cls == BRANCH && k == 1) ? cout : 1'($urandom_range(0, 1));
      if ((ec[k] & C_MREQ) != 6'h0) mem_ack = (k == n_ack);
      else mem_ack = 1'($urandom_range(0, 1));
      chk("strb", strb, es[k]);
      chk("ctl", ctl, ec[k]);
      chk("rf_idx", {rf_op_fa, rf_rd_index, rf_rs1_index, rf_rs2_index}, {fa, rd, rs1, rs2});
      tick();
    end
    if (!hold) in_valid = 1'b0;
    mem_ack = 1'b0;
    exp_err = timed_out;
    $display("instr cls=%0d cond=%0d n_ack=%0d hold=%0b cycles=%0d taken=%0b timeout=%0b",
             cls, cond, n_ack, hold, es.size(), taken, timed_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #2;
    chk("rst_strb", strb, 15'h0);
    chk("rst_ctl", ctl & 6'h1F, 6'h0);
    chk("rst_rf", {rf_op_fa, rf_rd_index, rf_rs1_index, rf_rs2_index}, 19'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rdy_after_rst", in_ready, 1'b1);

    // reset while a load waits for memory
    in_valid = 1'b1; op_class = LOAD; rd_index = 5'd9; rs1_index = 5'd2; rs2_index = 5'd4;
    tick();
    in_valid = 1'b0; mem_ack = 1'b0;
    tick();
    chk("mreq_before_rst", mem_req, 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mreq", mem_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", write_en, 1'b0);
    chk("rst_rd", rf_rd_index, 5'd0);
    tick();
    rst = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ctl", ctl, C_RDY);
    chk("late_ack_strb", strb, 15'h0);

    // directed cases from the class rules
    run_instr(SUB, LT, 4'h5, 5'd3, 5'd5, 5'd7, 1, 1'b0, 1'b0, 1'b0);
    run_instr(LOAD, LT, 4'h1, 5'd8, 5'd1, 5'd0, 4, 1'b0, 1'b0, 1'b0);
    run_instr(STORE, LT, 4'h2, 5'd0, 5'd6, 5'd7, 1, 1'b0, 1'b0, 1'b0);
    run_instr(BRANCH, LTU, 4'h0, 5'd0, 5'd1, 5'd2, 1, 1'b1, 1'b0, 1'b0);
    run_instr(BRANCH, GE, 4'h0, 5'd0, 5'd1, 5'd2, 1, 1'b1, 1'b1, 1'b0);
    run_instr(BRANCH, GEU, 4'h0, 5'd0, 5'd1, 5'd2, 1, 1'b0, 1'b1, 1'b0);
    run_instr(BRANCH, LT, 4'h0, 5'd0, 5'd1, 5'd2, 1, 1'b1, 1'b1, 1'b0);
    run_instr(4'd12, LT, 4'hF, 5'd31, 5'd30, 5'd29, 1, 1'b0, 1'b0, 1'b0);
`ifdef RF_SEQ_TIMEOUT_EN
    run_instr(STORE, LT, 4'h3, 5'd1, 5'd2, 5'd3, TO + 1, 1'b0, 1'b0, 1'b0);
    run_instr(STORE, LT, 4'h3, 5'd1, 5'd2, 5'd3, TO, 1'b0, 1'b0, 1'b0);
`endif
    // back-to-back with in_valid held high
    run_instr(ALU, LT, 4'h6, 5'd10, 5'd11, 5'd12, 1, 1'b0, 1'b0, 1'b1);
    run_instr(ALUI, LT, 4'h7, 5'd13, 5'd14, 5'd15, 1, 1'b0, 1'b0, 1'b1);
    run_instr(JAL, LT, 4'h8, 5'd16, 5'd17, 5'd18, 1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 10));
      if (c > 4'd8) c = 4'($urandom_range(9, 15));
      run_instr(c, 2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    chk("final_ctl", ctl, C_RDY | (exp_err ? C_ERR : 6'h0));
    tick();
    chk("final_idle", ctl, C_RDY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
